// File: rtl/ex_stage_if.sv
// Opcode encoding shared by decode and execute, and the ID/EX -> EX/MEM
// bundle seen by the execute stage.
package ex_pkg;
    localparam int ALU_OP_W  = 8;
    localparam int ALU_CHIP_W = 3;
    localparam int WORD_W    = 32;
    localparam int REG_W     = 5;

    localparam logic [2:0] CHIP_LOGIC = 3'd1;
    localparam logic [2:0] CHIP_SHIFT = 3'd2;
    localparam logic [2:0] CHIP_ARITH = 3'd3;
    localparam logic [2:0] CHIP_HILO  = 3'd4;
    localparam logic [2:0] CHIP_DIV   = 3'd5;

    localparam logic [4:0] F_AND  = 5'd0;
    localparam logic [4:0] F_OR   = 5'd1;
    localparam logic [4:0] F_XOR  = 5'd2;
    localparam logic [4:0] F_NOR  = 5'd3;
    localparam logic [4:0] F_LUI  = 5'd4;
    localparam logic [4:0] F_SLL  = 5'd0;
    localparam logic [4:0] F_SRL  = 5'd1;
    localparam logic [4:0] F_SRA  = 5'd2;
    localparam logic [4:0] F_ADD  = 5'd0;
    localparam logic [4:0] F_ADDU = 5'd1;
    localparam logic [4:0] F_SUB  = 5'd2;
    localparam logic [4:0] F_SUBU = 5'd3;
    localparam logic [4:0] F_SLT  = 5'd4;
    localparam logic [4:0] F_SLTU = 5'd5;
    localparam logic [4:0] F_MFHI = 5'd0;
    localparam logic [4:0] F_MFLO = 5'd1;
    localparam logic [4:0] F_MTHI = 5'd2;
    localparam logic [4:0] F_MTLO = 5'd3;
    localparam logic [4:0] F_DIV  = 5'd0;
    localparam logic [4:0] F_DIVU = 5'd1;

    localparam logic [7:0] OP_AND  = {CHIP_LOGIC, F_AND};
    localparam logic [7:0] OP_OR   = {CHIP_LOGIC, F_OR};
    localparam logic [7:0] OP_XOR  = {CHIP_LOGIC, F_XOR};
    localparam logic [7:0] OP_NOR  = {CHIP_LOGIC, F_NOR};
    localparam logic [7:0] OP_LUI  = {CHIP_LOGIC, F_LUI};
    localparam logic [7:0] OP_SLL  = {CHIP_SHIFT, F_SLL};
    localparam logic [7:0] OP_SRL  = {CHIP_SHIFT, F_SRL};
    localparam logic [7:0] OP_SRA  = {CHIP_SHIFT, F_SRA};
    localparam logic [7:0] OP_ADD  = {CHIP_ARITH, F_ADD};
    localparam logic [7:0] OP_ADDU = {CHIP_ARITH, F_ADDU};
    localparam logic [7:0] OP_SUB  = {CHIP_ARITH, F_SUB};
    localparam logic [7:0] OP_SUBU = {CHIP_ARITH, F_SUBU};
    localparam logic [7:0] OP_SLT  = {CHIP_ARITH, F_SLT};
    localparam logic [7:0] OP_SLTU = {CHIP_ARITH, F_SLTU};
    localparam logic [7:0] OP_MFHI = {CHIP_HILO, F_MFHI};
    localparam logic [7:0] OP_MFLO = {CHIP_HILO, F_MFLO};
    localparam logic [7:0] OP_MTHI = {CHIP_HILO, F_MTHI};
    localparam logic [7:0] OP_MTLO = {CHIP_HILO, F_MTLO};
    localparam logic [7:0] OP_DIV  = {CHIP_DIV, F_DIV};
    localparam logic [7:0] OP_DIVU = {CHIP_DIV, F_DIVU};
endpackage

interface ex_stage_if;
    import ex_pkg::*;
    logic [ALU_OP_W-1:0] ex_exOp;
    logic [WORD_W-1:0]   ex_src1;
    logic [WORD_W-1:0]   ex_src2;
    logic [REG_W-1:0]    ex_regDest;
    logic                ex_writeReg;
    logic [WORD_W-1:0]   mem_result;
    logic [REG_W-1:0]    mem_regDest;
    logic                mem_writeReg;
    logic                ex_overflow;
    logic                stall_req;

    modport master (
        output ex_exOp, ex_src1, ex_src2, ex_regDest, ex_writeReg,
        input  mem_result, mem_regDest, mem_writeReg, ex_overflow,
        input  stall_req
    );
    modport slave (
        input  ex_exOp, ex_src1, ex_src2, ex_regDest, ex_writeReg,
        output mem_result, mem_regDest, mem_writeReg, ex_overflow,
        output stall_req
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, HI/LO registers and a 32-step
// restoring divider that stalls the front end while it iterates.
module ex_stage
    import ex_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave ex
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;

    logic [2:0]  chip;
    logic [4:0]  fn;
    logic [31:0] a, b, sum, diff, result;
    logic        is_div, is_mt, ovf;

    assign chip   = ex.ex_exOp[7:5];
    assign fn     = ex.ex_exOp[4:0];
    assign a      = ex.ex_src1;
    assign b      = ex.ex_src2;
    assign sum    = a + b;
    assign diff   = a - b;
    assign is_div = (chip == CHIP_DIV);
    assign is_mt  = (chip == CHIP_HILO) &&
                    (fn == F_MTHI || fn == F_MTLO);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (1'b1)
            chip == CHIP_LOGIC: begin
                case (fn)
                    F_AND:   result = a & b;
                    F_OR:    result = a | b;
                    F_XOR:   result = a ^ b;
                    F_NOR:   result = ~(a | b);
                    F_LUI:   result = {b[15:0], 16'h0};
                    default: result = '0;
                endcase
            end
            chip == CHIP_SHIFT: begin
                case (fn)
                    F_SLL:   result = b << a[4:0];
                    F_SRL:   result = b >> a[4:0];
                    F_SRA:   result = $signed(b) >>> a[4:0];
                    default: result = '0;
                endcase
            end
            chip == CHIP_ARITH: begin
                case (fn)
                    F_ADD: begin
                        result = sum;
                        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
                    end
                    F_ADDU: result = sum;
                    F_SUB: begin
                        result = diff;
                        ovf = (a[31] != b[31]) && (diff[31] != a[31]);
                    end
                    F_SUBU:  result = diff;
                    F_SLT:   result = {31'b0, $signed(a) < $signed(b)};
                    F_SLTU:  result = {31'b0, a < b};
                    default: result = '0;
                endcase
            end
            chip == CHIP_HILO: begin
                case (fn)
                    F_MFHI:  result = hi_q;
                    F_MFLO:  result = lo_q;
                    default: result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    assign ex.mem_result   = result;
    assign ex.mem_regDest  = ex.ex_regDest;
    assign ex.mem_writeReg = ex.ex_writeReg & ~ovf & ~is_mt & ~is_div;
    assign ex.ex_overflow  = ovf & rst;
    // Gated by reset so an abandoned divide drops the stall immediately.
    assign ex.stall_req    = rst & ((state_q == S_BUSY) ||
                                    (state_q == S_IDLE && is_div));

    logic [32:0] sh;
    logic [31:0] tr;
    logic        ge, sgn, s1n, s2n;

    assign sh  = {rem_q, quo_q[31]};
    assign ge  = (sh >= {1'b0, dvs_q});
    assign tr  = sh[31:0] - dvs_q;
    assign sgn = (fn == F_DIV);
    assign s1n = sgn & a[31];
    assign s2n = sgn & b[31];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    if (b == '0) begin
                        rem_d   = a;
                        quo_d   = '1;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = s1n ? (32'd0 - a) : a;
                        dvs_d   = s2n ? (32'd0 - b) : b;
                        qneg_d  = s1n ^ s2n;
                        rneg_d  = s1n;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end else if (is_mt) begin
                    if (fn == F_MTHI) hi_d = a;
                    else              lo_d = a;
                end
            end
            S_BUSY: begin
                rem_d = ge ? tr : sh[31:0];
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: begin
                hi_d    = rneg_q ? (32'd0 - rem_q) : rem_q;
                lo_d    = qneg_q ? (32'd0 - quo_q) : quo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table plus divider, HI/LO and reset sequences.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    typedef struct {
        string       nm;
        logic [7:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        wr;
        logic [31:0] res;
        logic        ewr;
        logic        eovf;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        cres;
        logic [4:0]  rd;
        logic        wr;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [4:0] rd,
                         input logic wr);
        bus.ex_exOp     = op;
        bus.ex_src1     = s1;
        bus.ex_src2     = s2;
        bus.ex_regDest  = rd;
        bus.ex_writeReg = wr;
    endtask

    task automatic sb_check();
        exp_t e;
        logic bad;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        bad = (bus.mem_regDest !== e.rd) || (bus.mem_writeReg !== e.wr) ||
              (bus.ex_overflow !== e.ovf) || (bus.stall_req !== 1'b0) ||
              (e.cres && bus.mem_result !== e.res);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got res=%h rd=%0d wr=%b ovf=%b stall=%b want res=%h rd=%0d wr=%b ovf=%b stall=0",
                     e.nm, bus.mem_result, bus.mem_regDest, bus.mem_writeReg,
                     bus.ex_overflow, bus.stall_req, e.res, e.rd, e.wr, e.ovf);
        end
    endtask

    task automatic step(input string nm, input logic [7:0] op,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [4:0] rd, input logic wr,
                        input logic [31:0] res, input logic cres,
                        input logic ewr, input logic eovf);
        exp_t e;
        @(posedge clk);
        #1;
        drive(op, s1, s2, rd, wr);
        e.nm = nm; e.res = res; e.cres = cres;
        e.rd = rd; e.wr = ewr; e.ovf = eovf;
        sb.push_back(e);
        @(negedge clk);
        sb_check();
    endtask

    task automatic run_div(input string nm, input logic [7:0] op,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input int exp_stall);
        int n;
        @(posedge clk);
        #1;
        drive(op, s1, s2, 5'd3, 1'b1);
        @(negedge clk);
        chk({nm, " wr"}, {31'b0, bus.mem_writeReg}, 32'd0);
        n = 0;
        while (bus.stall_req === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({nm, " stall cycles"}, 32'(n), 32'(exp_stall));
    endtask

    task automatic rd_hilo(input string nm, input logic [31:0] lo,
                           input logic [31:0] hi);
        step({nm, " mflo"}, OP_MFLO, 32'h0, 32'h0, 5'd4, 1'b1, lo, 1'b1, 1'b1, 1'b0);
        step({nm, " mfhi"}, OP_MFHI, 32'h0, 32'h0, 5'd5, 1'b1, hi, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"and",  OP_AND,  32'hF0F0FFFF, 32'h0FF01234, 1'b1, 32'h00F01234, 1'b1, 1'b0};
        vecs[1]  = '{"or",   OP_OR,   32'hF0F00000, 32'h00000F0F, 1'b1, 32'hF0F00F0F, 1'b1, 1'b0};
        vecs[2]  = '{"xor",  OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'hF0F00F0F, 1'b1, 1'b0};
        vecs[3]  = '{"nor",  OP_NOR,  32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{"lui",  OP_LUI,  32'h00000000, 32'h00001234, 1'b1, 32'h12340000, 1'b1, 1'b0};
        vecs[5]  = '{"sll",  OP_SLL,  32'h00000004, 32'h00000001, 1'b1, 32'h00000010, 1'b1, 1'b0};
        vecs[6]  = '{"srl",  OP_SRL,  32'h00000004, 32'h80000000, 1'b1, 32'h08000000, 1'b1, 1'b0};
        vecs[7]  = '{"sra",  OP_SRA,  32'h00000004, 32'h80000000, 1'b1, 32'hF8000000, 1'b1, 1'b0};
        vecs[8]  = '{"add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[9]  = '{"addu", OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b0};
        vecs[10] = '{"sub_ovf", OP_SUB, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[11] = '{"subu", OP_SUBU, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[12] = '{"slt",  OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[13] = '{"sltu", OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{"add",  OP_ADD,  32'h00000003, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[15] = '{"slt_neg", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};

        drive(8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
        #3;
        chk("reset stall", {31'b0, bus.stall_req}, 32'd0);
        chk("reset ovf", {31'b0, bus.ex_overflow}, 32'd0);
        chk("reset result", bus.mem_result, 32'd0);
        chk("reset wr", {31'b0, bus.mem_writeReg}, 32'd0);
        drive(OP_MFHI, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("reset hi", bus.mem_result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].nm, vecs[i].op, vecs[i].s1, vecs[i].s2, 5'(i + 1),
                 vecs[i].wr, vecs[i].res, 1'b1, vecs[i].ewr, vecs[i].eovf);
        end

        step("mthi", OP_MTHI, 32'hDEADBEEF, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step("mfhi after mthi", OP_MFHI, 32'h0, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        step("mtlo", OP_MTLO, 32'h12345678, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step("mflo after mtlo", OP_MFLO, 32'h0, 32'h0, 5'd8, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);

        run_div("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 33);
        rd_hilo("div -7/2", 32'hFFFFFFFD, 32'hFFFFFFFF);

        run_div("divu 5/0", OP_DIVU, 32'h00000005, 32'h00000000, 1);
        rd_hilo("divu 5/0", 32'hFFFFFFFF, 32'h00000005);

        @(posedge clk);
        #1;
        drive(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        repeat (10) @(negedge clk);
        chk("pre-reset busy", {31'b0, bus.stall_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-div reset stall", {31'b0, bus.stall_req}, 32'd0);
        drive(OP_MFHI, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        chk("mid-div reset hi", bus.mem_result, 32'd0);
        drive(OP_MFLO, 32'h0, 32'h0, 5'd0, 1'b1);
        #1;
        chk("mid-div reset lo", bus.mem_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("divu 100/7", OP_DIVU, 32'd100, 32'd7, 33);
        rd_hilo("divu 100/7", 32'd14, 32'd2);

        run_div("b2b divu 100/7", OP_DIVU, 32'd100, 32'd7, 33);
        run_div("b2b divu 9/4", OP_DIVU, 32'd9, 32'd4, 33);
        rd_hilo("b2b divu 9/4", 32'd2, 32'd1);

        run_div("div -8/-3", OP_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 33);
        rd_hilo("div -8/-3", 32'd2, 32'hFFFFFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
